// File: rtl/fetch_queue.sv
// fetch_queue: single-outstanding instruction fetch engine feeding a small
// circular buffer of {pc, instr} entries toward decode. A redirect (flush)
// empties the buffer and turns any in-flight memory request into a drop.
module fetch_queue #(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        clr,
    input  logic        pc_valid,
    input  logic [31:0] pc_addr,
    output logic        pc_ready,
    input  logic        flush,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_data,
    output logic        id_valid,
    output logic [31:0] id_instr,
    output logic [31:0] id_pc,
    input  logic        id_ready,
    output logic [3:0]  count
);

    localparam int         PW      = $clog2(DEPTH);
    localparam logic [3:0] DEPTH_C = 4'(DEPTH);
    localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DROP = 2'd2
    } state_t;

    state_t        state;
    logic [31:0]   req_addr;
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [3:0]    cnt;
    logic [31:0]   pc_mem    [DEPTH];
    logic [31:0]   instr_mem [DEPTH];

    logic accept;
    logic push;
    logic pop;

    // Only take a new address when nothing is in flight and a slot is
    // guaranteed free for its result; a redirect blocks acceptance.
    assign pc_ready  = (state == IDLE) && (cnt < DEPTH_C) && !flush;
    assign accept    = pc_valid && pc_ready;
    assign push      = (state == WAIT) && imem_ack && !flush;
    assign pop       = id_valid && id_ready;

    assign imem_req  = (state == WAIT) || (state == DROP);
    assign imem_addr = req_addr;
    assign id_valid  = (cnt != 4'd0);
    assign id_pc     = pc_mem[rd_ptr];
    assign id_instr  = instr_mem[rd_ptr];
    assign count     = cnt;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == LAST) ? '0 : p + 1'b1;
    endfunction

    // Request FSM: tracks the single outstanding memory access and whether
    // its returning data is still wanted.
    always_ff @(posedge clk) begin
        if (!clr) begin
            state    <= IDLE;
            req_addr <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        req_addr <= pc_addr;
                        state    <= WAIT;
                    end
                end
                WAIT: begin
                    if (imem_ack)   state <= IDLE;
                    else if (flush) state <= DROP;
                end
                DROP: begin
                    if (imem_ack) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Buffer bookkeeping: pointers and occupancy; flush wipes everything.
    always_ff @(posedge clk) begin
        if (!clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (push) wr_ptr <= ptr_inc(wr_ptr);
            if (pop)  rd_ptr <= ptr_inc(rd_ptr);
            case ({push, pop})
                2'b10:   cnt <= cnt + 4'd1;
                2'b01:   cnt <= cnt - 4'd1;
                default: cnt <= cnt;
            endcase
        end
    end

    // Entry storage; contents need no reset since occupancy gates visibility.
    always_ff @(posedge clk) begin
        if (push && clr) begin
            pc_mem[wr_ptr]    <= req_addr;
            instr_mem[wr_ptr] <= imem_data;
        end
    end

endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: randomized stimulus in biased phases (streaming, fill,
// wrap, flush, reset), compared every cycle against a transaction-level
// model: a queue of delivered entries plus one pending-fetch record.
module tb_fetch_queue;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        clr;
    logic        pc_valid;
    logic [31:0] pc_addr;
    logic        pc_ready;
    logic        flush;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_data;
    logic        id_valid;
    logic [31:0] id_instr;
    logic [31:0] id_pc;
    logic        id_ready;
    logic [3:0]  count;

    always #5 clk = ~clk;

    fetch_queue #(.DEPTH(DEPTH)) dut (
        .clk       (clk),
        .clr       (clr),
        .pc_valid  (pc_valid),
        .pc_addr   (pc_addr),
        .pc_ready  (pc_ready),
        .flush     (flush),
        .imem_req  (imem_req),
        .imem_addr (imem_addr),
        .imem_ack  (imem_ack),
        .imem_data (imem_data),
        .id_valid  (id_valid),
        .id_instr  (id_instr),
        .id_pc     (id_pc),
        .id_ready  (id_ready),
        .count     (count)
    );

    int vecs = 0;
    int errs = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vecs++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference model: what decode should see, and the one fetch in flight.
    typedef struct {
        logic [31:0] pc;
        logic [31:0] ins;
    } ent_t;

    ent_t        q[$];
    bit          pend;       // a memory request is outstanding
    bit          pend_dead;  // its data must be thrown away
    logic [31:0] pend_addr;  // last accepted address (request register)

    int p_valid, p_ack, p_ready, p_flush, p_rst;

    function automatic bit roll(input int pct);
        return ($urandom_range(99) < pct);
    endfunction

    task automatic model_reset();
        q.delete();
        pend      = 1'b0;
        pend_dead = 1'b0;
        pend_addr = '0;
    endtask

    task automatic drive_random();
        clr       = !roll(p_rst);
        pc_valid  = roll(p_valid);
        pc_addr   = $urandom();
        flush     = roll(p_flush);
        id_ready  = roll(p_ready);
        imem_ack  = roll(p_ack);
        imem_data = $urandom();
    endtask

    task automatic check_and_advance();
        bit   exp_pr;
        bit   take;
        ent_t e;
        exp_pr = !pend && (q.size() < DEPTH) && !flush;
        chk("pc_ready",  {31'd0, pc_ready}, {31'd0, exp_pr});
        chk("id_valid",  {31'd0, id_valid}, {31'd0, q.size() != 0});
        chk("count",     {28'd0, count},    32'(q.size()));
        chk("imem_req",  {31'd0, imem_req}, {31'd0, pend});
        chk("imem_addr", imem_addr,         pend_addr);
        if (q.size() != 0) begin
            chk("id_pc",    id_pc,    q[0].pc);
            chk("id_instr", id_instr, q[0].ins);
        end
        // next-state of the model at the coming rising edge
        if (!clr) begin
            model_reset();
        end else begin
            take = pc_valid && exp_pr;
            if (flush) begin
                q.delete();
            end else begin
                if (id_ready && q.size() != 0) void'(q.pop_front());
                if (pend && !pend_dead && imem_ack) begin
                    e.pc  = pend_addr;
                    e.ins = imem_data;
                    q.push_back(e);
                end
            end
            if (pend && imem_ack) begin
                pend      = 1'b0;
                pend_dead = 1'b0;
            end else if (pend && flush) begin
                pend_dead = 1'b1;
            end
            if (take) begin
                pend      = 1'b1;
                pend_dead = 1'b0;
                pend_addr = pc_addr;
            end
        end
    endtask

    initial begin
        clr = 1'b0; pc_valid = 1'b0; pc_addr = '0; flush = 1'b0;
        id_ready = 1'b0; imem_ack = 1'b0; imem_data = '0;
        repeat (2) @(posedge clk);
        model_reset();
        @(negedge clk);
        clr = 1'b1;
        #1;
        chk("rst_pc_ready", {31'd0, pc_ready}, 32'd1);
        chk("rst_count",    {28'd0, count},    32'd0);
        chk("rst_imem_req", {31'd0, imem_req}, 32'd0);
        chk("rst_imem_addr", imem_addr,        32'd0);
        chk("rst_id_valid", {31'd0, id_valid}, 32'd0);
        @(posedge clk);

        for (int ph = 0; ph < 6; ph++) begin
            case (ph)
                0: begin p_valid = 100; p_ack = 100; p_ready = 100; p_flush = 0;  p_rst = 0; end
                1: begin p_valid = 100; p_ack = 60;  p_ready = 0;   p_flush = 0;  p_rst = 0; end
                2: begin p_valid = 80;  p_ack = 50;  p_ready = 50;  p_flush = 0;  p_rst = 0; end
                3: begin p_valid = 80;  p_ack = 40;  p_ready = 50;  p_flush = 15; p_rst = 0; end
                4: begin p_valid = 70;  p_ack = 50;  p_ready = 60;  p_flush = 10; p_rst = 3; end
                default: begin p_valid = 90; p_ack = 70; p_ready = 30; p_flush = 5; p_rst = 2; end
            endcase
            for (int c = 0; c < 400; c++) begin
                @(negedge clk);
                drive_random();
                #1;
                check_and_advance();
            end
        end

        @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
